fp32_accumulator: RTL and testbench

//   Consumes the FP32 product stream of the BF16 multiplier and reduces each

---
 rtl/fp32_accumulator.sv | 174 +++++++++++++++++
 tb/tb_fp32_accumulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_accumulator.sv
// Reduces a framed stream of FP32 products to one FP32 sum per vector (single-cycle FP32 add in the loop).
// Latency: the beat that closes a vector is accepted in cycle N and its result is valid in cycle N+1.
// Backpressure: in_ready = !out_valid || out_ready; the result stays stable while out_valid && !out_ready.
module fp32_accumulator #(
    parameter int MAX_TERMS = 64,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_data,
    input  logic             i_in_first,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_data,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_trunc
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit value (27 when the value is zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // IEEE-754 binary32 add, round to nearest even, subnormals kept.
    // The smaller operand is aligned into a 27-bit field (24 mantissa bits + guard,
    // round, sticky); the sticky bit is OR-ed into the LSB so the odd LSB marks
    // "value lies strictly between two even neighbours", which keeps both the add
    // and the subtract paths correctly rounded.
    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, sx, sy, swap, a_nan, b_nan, a_inf, b_inf, sticky, rup;
        logic [7:0]  ea, eb, ex, ey, dx, dy, d;
        logic [22:0] fa, fb, fx, fy;
        logic [23:0] mx, my;
        logic [26:0] big, sm_full, sm, back, n;
        logic [27:0] s;
        logic [9:0]  e, sh, ef;
        logic [4:0]  lz;
        logic [24:0] mr;
        logic [22:0] frac;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        a_nan = (ea == 8'hFF) && (fa != 23'd0);
        b_nan = (eb == 8'hFF) && (fb != 23'd0);
        a_inf = (ea == 8'hFF) && (fa == 23'd0);
        b_inf = (eb == 8'hFF) && (fb == 23'd0);
        // Order operands by magnitude so the subtract path never goes negative.
        swap = {eb, fb} > {ea, fa};
        sx = swap ? sb : sa;  ex = swap ? eb : ea;  fx = swap ? fb : fa;
        sy = swap ? sa : sb;  ey = swap ? ea : eb;  fy = swap ? fa : fb;
        mx = {(ex != 8'd0), fx};
        my = {(ey != 8'd0), fy};
        dx = (ex == 8'd0) ? 8'd1 : ex;
        dy = (ey == 8'd0) ? 8'd1 : ey;
        d  = dx - dy;
        big     = {mx, 3'b000};
        sm_full = {my, 3'b000};
        if (d >= 8'd27) begin
            sm     = '0;
            sticky = |my;
        end else begin
            sm     = sm_full >> d;
            back   = sm << d;
            sticky = (back != sm_full);
        end
        sm[0] = sm[0] | sticky;
        s = (sx == sy) ? ({1'b0, big} + {1'b0, sm}) : ({1'b0, big} - {1'b0, sm});
        e = {2'b00, dx};
        if (s[27]) begin
            n  = {s[27:2], s[1] | s[0]};
            e  = e + 10'd1;
        end else begin
            // Normalise left, but never below the minimum exponent (subnormal result).
            lz = lzc27(s[26:0]);
            sh = (10'(lz) < (e - 10'd1)) ? 10'(lz) : (e - 10'd1);
            n  = s[26:0] << sh;
            e  = e - sh;
        end
        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + 25'(rup);
        if (mr[24]) begin
            ef   = e + 10'd1;
            frac = 23'd0;
        end else begin
            ef   = mr[23] ? e : 10'd0;
            frac = mr[22:0];
        end
        if (a_nan || b_nan)                return QNAN;
        if (a_inf && b_inf && (sa != sb)) return QNAN;
        if (a_inf)                        return a;
        if (b_inf)                        return b;
        if (s == 28'd0)                   return {sa & sb, 31'd0};
        if (ef >= 10'd255)                return {sx, 8'hFF, 23'd0};
        return {sx, ef[7:0], frac};
    endfunction

    state_t             r_state;
    logic [31:0]        r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_trunc;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_ending;
    logic [31:0]        w_sum;
    logic [31:0]        w_new_acc;
    logic [CNT_W-1:0]   w_new_count;

    assign w_in_ready  = !r_out_valid || i_out_ready;
    assign w_accept    = i_in_valid && w_in_ready;
    // Any beat arriving with no vector open (IDLE or HOLD) opens a fresh one.
    assign w_start     = i_in_first || (r_state != S_ACCUM);
    assign w_sum       = fpadd(r_acc, i_in_data);
    assign w_new_acc   = w_start ? i_in_data : w_sum;
    assign w_new_count = w_start ? CNT_W'(1) : (r_count + CNT_W'(1));
    assign w_ending    = i_in_last || (w_new_count == CNT_W'(MAX_TERMS));

    // Framing FSM, accumulator and registered result handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_new_acc;
            r_count <= w_new_count;
            if (w_ending) begin
                // Back-to-back results: a result taken this cycle is replaced without a bubble.
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
                r_out_data  <= w_new_acc;
                r_out_count <= w_new_count;
                r_out_trunc <= !i_in_last;
            end else begin
                r_state     <= S_ACCUM;
                r_out_valid <= 1'b0;
            end
        end else if (r_out_valid && i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_count = r_out_count;
    assign o_out_trunc = r_out_trunc;

endmodule

// File: tb/tb_fp32_accumulator.sv
// Self-checking bench for fp32_accumulator: directed cases plus a random stream.
// Reference sums are formed exactly in wide integers and rounded once per add.
// A second instance with MAX_TERMS=4 covers the forced-termination case.
module tb_fp32_accumulator;

    localparam int MT = 64;
    localparam int CW = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;

    logic          in_valid, in_first, in_last, out_ready;
    logic [31:0]   in_data;
    logic          in_ready, out_valid, out_trunc;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;

    logic          t4_in_valid, t4_in_first, t4_in_last, t4_out_ready;
    logic [31:0]   t4_in_data;
    logic          t4_in_ready, t4_out_valid, t4_out_trunc;
    logic [31:0]   t4_out_data;
    logic [2:0]    t4_out_count;

    fp32_accumulator #(.MAX_TERMS(MT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_in_first(in_first), .i_in_last(in_last),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_count(out_count), .o_out_trunc(out_trunc)
    );

    fp32_accumulator #(.MAX_TERMS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(t4_in_valid), .o_in_ready(t4_in_ready), .i_in_data(t4_in_data),
        .i_in_first(t4_in_first), .i_in_last(t4_in_last),
        .o_out_valid(t4_out_valid), .i_out_ready(t4_out_ready), .o_out_data(t4_out_data),
        .o_out_count(t4_out_count), .o_out_trunc(t4_out_trunc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pending;
    bit          m_open;
    logic [31:0] m_data;
    int          m_count;
    bit          m_trunc;
    logic [31:0] m_terms[$];

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Magnitude in units of 2^-149 (the subnormal LSB).
    function automatic logic [299:0] to_mag(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 300'(x[22:0]);
        return 300'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
    endfunction

    // Exact sum, then a single round-to-nearest-even into binary32.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, rem, half;
        logic         s;
        logic [24:0]  q;
        int           p, sh, ef;
        if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
        if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        ma = to_mag(a);
        mb = to_mag(b);
        if (a[31] == b[31])  begin mag = ma + mb; s = a[31]; end
        else if (ma >= mb)   begin mag = ma - mb; s = a[31]; end
        else                 begin mag = mb - ma; s = b[31]; end
        if (mag == 300'd0) return {a[31] & b[31], 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {s, 7'd0, mag[23], mag[22:0]};
        sh   = p - 23;
        q    = 25'(mag >> sh);
        rem  = mag & ((300'(1) << sh) - 300'(1));
        half = 300'(1) << (sh - 1);
        if ((rem > half) || ((rem == half) && q[0])) q = q + 25'd1;
        if (q[24]) begin q = q >> 1; sh++; end
        ef = sh + 1;
        if (ef >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(ef), q[22:0]};
    endfunction

    function automatic logic [31:0] fold_terms();
        logic [31:0] acc;
        acc = m_terms[0];
        for (int i = 1; i < m_terms.size(); i++) acc = ref_add(acc, m_terms[i]);
        return acc;
    endfunction

    function automatic logic [31:0] rnd_fp();
        int          c;
        logic        s;
        logic [22:0] m;
        c = $urandom_range(0, 39);
        s = 1'($urandom);
        m = 23'($urandom);
        if (c == 0)       return ($urandom_range(0, 1) == 0) ? {s, 8'hFF, 23'd0} : {s, 8'hFF, m | 23'd1};
        else if (c <= 4)  return {s, 8'h00, m};
        else if (c <= 6)  return {s, 31'd0};
        else if (c <= 10) return $urandom;
        else if (c <= 13) return {s, 8'($urandom_range(250, 254)), m};
        else if (c <= 16) return {s, 8'($urandom_range(1, 4)), m};
        else              return {s, 8'($urandom_range(120, 135)), m};
    endfunction

    // One cycle on the main instance: drive at the falling edge, predict, check at the next falling edge.
    task automatic step(input bit v, input logic [31:0] d, input bit f, input bit l, input bit ordy);
        bit acc;
        in_valid = v; in_data = d; in_first = f; in_last = l; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_pending || ordy));
        acc = v && (!m_pending || ordy);
        if (m_pending && ordy) m_pending = 0;
        if (acc) begin
            if (f || !m_open) m_terms.delete();
            m_terms.push_back(d);
            if (l || (m_terms.size() == MT)) begin
                m_pending = 1;
                m_data    = fold_terms();
                m_count   = m_terms.size();
                m_trunc   = !l;
                m_open    = 0;
            end else begin
                m_open = 1;
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_pending));
        if (m_pending) begin
            chk("out_data",  out_data,         m_data);
            chk("out_count", 32'(out_count),   32'(m_count));
            chk("out_trunc", 32'(out_trunc),   32'(m_trunc));
        end
    endtask

    task automatic step4(input logic [31:0] d, input bit f, input bit l);
        t4_in_valid = 1'b1; t4_in_data = d; t4_in_first = f; t4_in_last = l; t4_out_ready = 1'b1;
        @(negedge clk);
        t4_in_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_pending = 0;
        m_open    = 0;
        m_terms.delete();
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_first = 0; in_last = 0; out_ready = 0;
        t4_in_valid = 0; t4_in_data = '0; t4_in_first = 0; t4_in_last = 0; t4_out_ready = 1;
        model_clear();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_trunc", 32'(out_trunc), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst4_out_valid", 32'(t4_out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 1+2+3
        step(1, 32'h3F80_0000, 1, 0, 1);
        step(1, 32'h4000_0000, 0, 0, 1);
        step(1, 32'h4040_0000, 0, 1, 1);
        chk("t1_data",  out_data,       32'h40C0_0000);
        chk("t1_count", 32'(out_count), 32'd3);
        chk("t1_trunc", 32'(out_trunc), 32'd0);

        // T2: repeated ties round to even
        step(1, 32'h4B80_0000, 1, 0, 1);
        step(1, 32'h3F80_0000, 0, 0, 1);
        step(1, 32'h3F80_0000, 0, 1, 1);
        chk("t2_tie_even", out_data, 32'h4B80_0000);

        // T3: subnormal sum, overflow, inf - inf
        step(1, 32'h0040_0000, 1, 0, 1);
        step(1, 32'h0040_0000, 0, 1, 1);
        chk("t3_subnorm", out_data, 32'h0080_0000);
        step(1, 32'h7F7F_FFFF, 1, 0, 1);
        step(1, 32'h7F7F_FFFF, 0, 1, 1);
        chk("t3_overflow", out_data, 32'h7F80_0000);
        step(1, 32'h7F80_0000, 1, 0, 1);
        step(1, 32'hFF80_0000, 0, 1, 1);
        chk("t3_inf_minus_inf", out_data, 32'h7FC0_0000);
        step(1, 32'h8000_0000, 1, 0, 1);
        step(1, 32'h8000_0000, 0, 1, 1);
        chk("t3_neg_zero", out_data, 32'h8000_0000);
        step(0, 32'd0, 0, 0, 1);

        // T4: forced termination at MAX_TERMS=4 on the second instance
        for (int i = 0; i < 6; i++) begin
            step4(32'h3F80_0000, i == 0, 0);
            if (i == 3) begin
                chk("t4_valid", 32'(t4_out_valid), 32'd1);
                chk("t4_data",  t4_out_data,       32'h4080_0000);
                chk("t4_count", 32'(t4_out_count), 32'd4);
                chk("t4_trunc", 32'(t4_out_trunc), 32'd1);
            end
            if (i >= 4) chk("t4_open", 32'(t4_out_valid), 32'd0);
        end
        step4(32'h3F80_0000, 0, 1);
        chk("t4_tail_data",  t4_out_data,       32'h4040_0000);
        chk("t4_tail_count", 32'(t4_out_count), 32'd3);
        chk("t4_tail_trunc", 32'(t4_out_trunc), 32'd0);

        // Truncation at the default MAX_TERMS, then the spill-over vector
        for (int i = 0; i < 70; i++) begin
            step(1, 32'h3F80_0000, i == 0, 0, 1);
            if (i == 63) begin
                chk("trunc64_data",  out_data,       32'h4280_0000);
                chk("trunc64_count", 32'(out_count), 32'd64);
                chk("trunc64_trunc", 32'(out_trunc), 32'd1);
            end
        end
        step(1, 32'h3F80_0000, 0, 1, 1);
        chk("spill_count", 32'(out_count), 32'd7);

        // T5: back-pressure, then simultaneous take + one-term vector
        step(1, 32'h3F80_0000, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h4040_0000, 1, 0, 0);
            chk("t5_in_ready_low", 32'(in_ready), 32'd0);
            chk("t5_stable",       out_data,      32'h3F80_0000);
        end
        step(1, 32'h40A0_0000, 1, 1, 1);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_data",  out_data,       32'h40A0_0000);
        chk("t5_count", 32'(out_count), 32'd1);

        // Asynchronous reset while a result is held
        step(1, 32'h3F80_0000, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_pending_valid", 32'(out_valid), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T6: reset mid-vector, then a fresh vector
        step(1, 32'h3F80_0000, 1, 0, 1);
        step(1, 32'h4000_0000, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_result", 32'(out_valid), 32'd0);
        step(1, 32'h4040_0000, 1, 0, 1);
        step(1, 32'h4080_0000, 0, 1, 1);
        chk("t6_fresh_sum", out_data, 32'h40E0_0000);

        // Random stream
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 3) != 0), rnd_fp(), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        step(0, 32'd0, 0, 0, 1);
        step(0, 32'd0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
